// File: rtl/buffer_fifo.sv
// buffer_fifo: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, flush, sticky error flags and
// an optional first-word-fall-through read port.
//
// All state changes on the rising edge of clk. Status outputs are decoded
// from registered state only, so none of them depends combinationally on
// we or re. The count register is one bit wider than the pointers, which
// lets every one of the 2^ADDR_L entries be used.

module buffer_fifo #(
    parameter int BUF_ID    = 0,
    parameter int ADDR_L    = 5,
    parameter int DATA_L    = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (1 << ADDR_L) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              we,
    input  logic [DATA_L-1:0] din,
    input  logic              re,
    output logic [DATA_L-1:0] dout,
    output logic              dout_valid,
    output logic              w_ack,
    output logic              r_ack,
    output logic              full,
    output logic              avail,
    output logic              afull,
    output logic              aempty,
    output logic [ADDR_L:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_L;

    // Thresholds are brought to the width of the count register once, so
    // every comparison below is between equal-width operands.
    localparam logic [ADDR_L:0] DEPTH_C  = (ADDR_L+1)'(DEPTH);
    localparam logic [ADDR_L:0] AFULL_C  = (ADDR_L+1)'(AFULL_TH);
    localparam logic [ADDR_L:0] AEMPTY_C = (ADDR_L+1)'(AEMPTY_TH);

    logic [DATA_L-1:0] mem [DEPTH];
    logic [ADDR_L-1:0] wpt;
    logic [ADDR_L-1:0] rpt;
    logic [ADDR_L:0]   count_q;
    logic              clear;
    logic              rd_ok;
    logic              wr_ok;

    // Reset and flush clear the same state; only the storage array is left alone.
    assign clear = ~rst_n | flush;

    // Status flags decoded from the registered occupancy.
    assign count  = count_q;
    assign full   = (count_q == DEPTH_C);
    assign avail  = (count_q != '0);
    assign afull  = (count_q >= AFULL_C);
    assign aempty = (count_q <= AEMPTY_C);

    // A pop is accepted whenever there is data; a push into a full FIFO is
    // accepted only when the same cycle also pops, freeing the slot.
    assign rd_ok = re & avail;
    assign wr_ok = we & (~full | rd_ok);

    // Storage array: written only on an accepted push, never cleared.
    always_ff @(posedge clk) begin
        if (!clear && wr_ok) begin
            mem[wpt] <= din;
        end
    end

    // Pointers wrap naturally at 2^ADDR_L; count tracks pushes minus pops.
    always_ff @(posedge clk) begin
        if (clear) begin
            wpt     <= '0;
            rpt     <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wpt <= wpt + 1'b1;
            end
            if (rd_ok) begin
                rpt <= rpt + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Acknowledge pulses follow an accepted transfer by one cycle; the error
    // flags stay set until the next reset or flush.
    always_ff @(posedge clk) begin
        if (clear) begin
            w_ack     <= 1'b0;
            r_ack     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            w_ack <= wr_ok;
            r_ack <= rd_ok;
            if (we && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (re && !avail) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; it is zero whenever the FIFO is empty.
            assign dout       = avail ? mem[rpt] : '0;
            assign dout_valid = avail;
        end else begin : g_registered
            logic [DATA_L-1:0] dout_q;
            logic              dout_valid_q;

            // Registered read: dout changes only on an accepted pop, and a
            // rejected pop withdraws the valid indication but keeps the data.
            always_ff @(posedge clk) begin
                if (clear) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else if (rd_ok) begin
                    dout_q       <= mem[rpt];
                    dout_valid_q <= 1'b1;
                end else if (re) begin
                    dout_valid_q <= 1'b0;
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
        end
    endgenerate

`ifndef SYNTHESIS
    // Simulation trace of dropped transfers, tagged with the instance id.
    always @(posedge clk) begin
        if (rst_n && !flush) begin
            if (we && !wr_ok) begin
                $display("buffer_fifo %0d: write dropped while full, wpt=%0d rpt=%0d",
                         BUF_ID, wpt, rpt);
            end
            if (re && !avail) begin
                $display("buffer_fifo %0d: read refused while empty, wpt=%0d rpt=%0d",
                         BUF_ID, wpt, rpt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_buffer_fifo.sv
// tb_buffer_fifo: drives a registered-read and a first-word-fall-through
// instance with identical stimulus and compares both against a queue-based
// reference model, plus a directed vector table for the corner cases.

module tb_buffer_fifo;

    localparam int ADDR_L = 2;
    localparam int DATA_L = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              we;
    logic              re;
    logic [DATA_L-1:0] din;

    logic [DATA_L-1:0] a_dout, b_dout;
    logic              a_dv, a_wack, a_rack, a_full, a_avail, a_afull, a_aempty, a_ovf, a_unf;
    logic              b_dv, b_wack, b_rack, b_full, b_avail, b_afull, b_aempty, b_ovf, b_unf;
    logic [ADDR_L:0]   a_count, b_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_dout0;
    logic       m_dv0, m_wack, m_rack, m_ovf, m_unf;

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       we;
        logic       re;
        logic [7:0] din;
        int         count;
        logic [7:0] dout;
        logic       dv;
        logic       wack;
        logic       rack;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vt[$];

    buffer_fifo #(
        .BUF_ID(0), .ADDR_L(ADDR_L), .DATA_L(DATA_L), .FWFT(0),
        .AFULL_TH(3), .AEMPTY_TH(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .we(we), .din(din), .re(re),
        .dout(a_dout), .dout_valid(a_dv), .w_ack(a_wack), .r_ack(a_rack),
        .full(a_full), .avail(a_avail), .afull(a_afull), .aempty(a_aempty),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    buffer_fifo #(
        .BUF_ID(1), .ADDR_L(ADDR_L), .DATA_L(DATA_L), .FWFT(1),
        .AFULL_TH(3), .AEMPTY_TH(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .we(we), .din(din), .re(re),
        .dout(b_dout), .dout_valid(b_dv), .w_ack(b_wack), .r_ack(b_rack),
        .full(b_full), .avail(b_avail), .afull(b_afull), .aempty(b_aempty),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Queue model: a pop takes the front, a push appends; capacity is DEPTH.
    task automatic modelStep(input logic r, input logic f, input logic w,
                             input logic rd, input logic [7:0] d);
        bit rdok, wrok;
        if (!r || f) begin
            mq.delete();
            m_dout0 = 8'h00;
            m_dv0   = 1'b0;
            m_wack  = 1'b0;
            m_rack  = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            rdok = rd && (mq.size() > 0);
            wrok = w && ((mq.size() < DEPTH) || rdok);
            if (rdok) begin
                m_dout0 = mq.pop_front();
                m_dv0   = 1'b1;
            end else if (rd) begin
                m_dv0 = 1'b0;
            end
            if (wrok) mq.push_back(d);
            m_wack = wrok;
            m_rack = rdok;
            if (w && !wrok) m_ovf = 1'b1;
            if (rd && !rdok) m_unf = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic w,
                                 input logic rd, input logic [7:0] d);
        rst_n = r;
        flush = f;
        we    = w;
        re    = rd;
        din   = d;
        @(posedge clk);
        modelStep(r, f, w, rd, d);
        #1;
    endtask

    task automatic checkOutput();
        int n;
        logic [7:0] head;
        n    = mq.size();
        head = (n != 0) ? mq[0] : 8'h00;
        chk("a.count",  32'(a_count),  32'(n));
        chk("a.full",   32'(a_full),   32'(n == DEPTH));
        chk("a.avail",  32'(a_avail),  32'(n != 0));
        chk("a.afull",  32'(a_afull),  32'(n >= 3));
        chk("a.aempty", 32'(a_aempty), 32'(n <= 1));
        chk("a.dout",   32'(a_dout),   32'(m_dout0));
        chk("a.dv",     32'(a_dv),     32'(m_dv0));
        chk("a.wack",   32'(a_wack),   32'(m_wack));
        chk("a.rack",   32'(a_rack),   32'(m_rack));
        chk("a.ovf",    32'(a_ovf),    32'(m_ovf));
        chk("a.unf",    32'(a_unf),    32'(m_unf));
        chk("b.count",  32'(b_count),  32'(n));
        chk("b.full",   32'(b_full),   32'(n == DEPTH));
        chk("b.afull",  32'(b_afull),  32'(n >= 3));
        chk("b.aempty", 32'(b_aempty), 32'(n <= 1));
        chk("b.dout",   32'(b_dout),   32'(head));
        chk("b.dv",     32'(b_dv),     32'(n != 0));
        chk("b.wack",   32'(b_wack),   32'(m_wack));
        chk("b.rack",   32'(b_rack),   32'(m_rack));
        chk("b.ovf",    32'(b_ovf),    32'(m_ovf));
        chk("b.unf",    32'(b_unf),    32'(m_unf));
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic w, input logic rd,
                                input logic [7:0] d, input int c, input logic [7:0] o,
                                input logic v, input logic wa, input logic ra,
                                input logic ov, input logic un);
        vec_t t;
        t.rst_n = r;  t.flush = f;  t.we = w;  t.re = rd;  t.din = d;
        t.count = c;  t.dout = o;   t.dv = v;  t.wack = wa; t.rack = ra;
        t.ovf = ov;   t.unf = un;
        return t;
    endfunction

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        din   = 8'h00;

        // Directed vectors, expectations for the registered-read instance.
        //                 rst f  we re din    cnt dout  dv wa ra ov un
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 8'h11, 1, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 8'h22, 2, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 8'h33, 3, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 8'h44, 4, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 3, 8'h11, 1, 0, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 2, 8'h22, 1, 0, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 1, 8'h33, 1, 0, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 0, 8'h44, 1, 0, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 0, 8'h44, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h11, 1, 8'h44, 0, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h22, 2, 8'h44, 0, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h33, 3, 8'h44, 0, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h44, 4, 8'h44, 0, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h55, 4, 8'h44, 0, 0, 0, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 8'h66, 4, 8'h11, 1, 1, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 3, 8'h22, 1, 0, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 2, 8'h33, 1, 0, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 1, 8'h44, 1, 0, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 0, 8'h66, 1, 0, 1, 1, 1));
        vt.push_back(mk(1, 1, 1, 0, 8'h99, 0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 1, 8'h77, 1, 8'h00, 0, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 0, 1, 8'h00, 0, 8'h77, 1, 0, 1, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h01, 1, 8'h77, 1, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h02, 2, 8'h77, 1, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 8'h03, 3, 8'h77, 1, 1, 0, 0, 1));
        vt.push_back(mk(1, 1, 1, 0, 8'h04, 0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 8'h05, 1, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 8'h06, 2, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 8'h07, 0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            applyStimulus(vt[i].rst_n, vt[i].flush, vt[i].we, vt[i].re, vt[i].din);
            checkOutput();
            chk($sformatf("vec%0d.count", i), 32'(a_count), 32'(vt[i].count));
            chk($sformatf("vec%0d.dout", i),  32'(a_dout),  32'(vt[i].dout));
            chk($sformatf("vec%0d.dv", i),    32'(a_dv),    32'(vt[i].dv));
            chk($sformatf("vec%0d.wack", i),  32'(a_wack),  32'(vt[i].wack));
            chk($sformatf("vec%0d.rack", i),  32'(a_rack),  32'(vt[i].rack));
            chk($sformatf("vec%0d.ovf", i),   32'(a_ovf),   32'(vt[i].ovf));
            chk($sformatf("vec%0d.unf", i),   32'(a_unf),   32'(vt[i].unf));
        end

        // Fall-through instance: a word written into an empty FIFO shows the
        // next cycle and disappears the cycle after it is popped.
        applyStimulus(1, 0, 1, 0, 8'hA5);
        checkOutput();
        chk("fwft.write.dout", 32'(b_dout), 32'h0000_00A5);
        chk("fwft.write.dv",   32'(b_dv),   32'h1);
        applyStimulus(1, 0, 0, 1, 8'h00);
        checkOutput();
        chk("fwft.pop.dv",   32'(b_dv),   32'h0);
        chk("fwft.pop.dout", 32'(b_dout), 32'h0);

        // Randomised traffic in alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            logic r, f, w, rd;
            bit   wheavy;
            wheavy = ((i / 40) % 2) == 0;
            r  = ($urandom_range(0, 199) != 0);
            f  = ($urandom_range(0, 99) == 0);
            w  = wheavy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            rd = wheavy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            applyStimulus(r, f, w, rd, 8'($urandom_range(0, 255)));
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
